dbus_interconnect: RTL and testbench
====================================

# dbus_interconnect

Parametrised data-bus interconnect between a hart's data port and `NUM_SLAVES` memory-mapped slaves (boot RAM, main memory, peripherals). It decodes addresses into uniform power-of-two regions and registers each request. It tolerates variable-latency slaves through a ready handshake. Unmapped, malformed or unresponsive accesses terminate with a bus-error flag instead of hanging the hart.

## Interface

- `NUM_SLAVES`, 4: number of slave regions (1..16).
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width, multiple of 8; strobe width `SW = DATA_W/8`.
- `REGION_BITS`, 12: log2 of region size in bytes.
- `BASE_ADDR`, 0: byte address of slave 0. Slave i occupies `BASE_ADDR + i*2^REGION_BITS`.
- `TIMEOUT`, 15: maximum ACCESS cycles before an error. 0 disables the timeout.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `m_rd` in 1: master read request.
- `m_wr` in SW: master byte write strobes; any bit set = write request.
- `m_addr` in ADDR_W: master byte address.
- `m_wdata` in DATA_W: master write data.
- `m_rdata` out DATA_W: read data, valid while `m_ready`.
- `m_ready` out 1: one-cycle transaction-complete pulse.
- `m_err` out 1: error qualifier, valid while `m_ready`.
- `s_cs` out NUM_SLAVES: one-hot slave select.
- `s_rd` out 1: read strobe to the selected slave.
- `s_wr` out SW: write strobes to the selected slave.
- `s_addr` out REGION_BITS: offset within the region.
- `s_wdata` out DATA_W: write data to the slaves.
- `s_rdata` in NUM_SLAVES*DATA_W: slave i read data at bits `[i*DATA_W +: DATA_W]`.
- `s_ready` in NUM_SLAVES: slave i completion, valid only while `s_cs[i]`.

## Operation

- FSM states: IDLE, ACCESS, RESP.
- **IDLE:** when `m_rd | (|m_wr)`:
  - Latch addr, wdata, strobes, read/write kind and decoded index.
  - Compute `idx = (m_addr - BASE_ADDR) >> REGION_BITS`.
  - **Miss:** `m_addr < BASE_ADDR`, `idx >= NUM_SLAVES`, or `m_rd` together with nonzero `m_wr`. Set the error flag and go to RESP with no slave access.
  - **Otherwise:** clear the timeout counter and go to ACCESS.
- **ACCESS:**
  - Drive `s_cs[idx]=1` and `s_addr` = latched `addr[REGION_BITS-1:0]`.
  - Drive `s_rd` / `s_wr` / `s_wdata` from the latched values.
  - On `s_ready[idx]`: capture `s_rdata` slice `idx` (reads only; writes capture 0), then go to RESP with error clear.
  - Otherwise increment the counter. When the counter reaches `TIMEOUT-1` without ready: capture 0, set the error flag, go to RESP.
  - `s_ready` bits of non-selected slaves are ignored.
- **RESP:**
  - Drive `m_ready=1` for exactly one cycle, with `m_rdata` = captured data and `m_err` = the error flag. Return to IDLE.
  - On error, `m_rdata` = 0.
- Master holds its request stable until `m_ready` and deasserts it in the cycle after `m_ready`. A request still asserted in the IDLE cycle after RESP is treated as a new transaction.
- All slave-side strobes and `s_cs` are 0 outside ACCESS. `s_addr` and `s_wdata` may hold their last values.
- Timeout counter width is `$clog2(TIMEOUT+1)` and the counter never wraps.

## Timing

- **Reset (async assert):** state=IDLE; `m_ready`, `m_err`, `m_rdata`, `s_cs`, `s_rd`, `s_wr`, `s_addr`, `s_wdata` and the counter are 0. Reset deassertion is synchronised by the integrator.
- **Reset mid-ACCESS:** `s_cs` and the strobes drop immediately and no `m_ready` is produced.
- **Hit, zero-wait slave:** request sampled at cycle 0, ACCESS at cycle 1, `m_ready` at cycle 2. Next request is sampled at cycle 3.
- **Wait states:** each cycle of low `s_ready` adds one cycle. `m_ready` comes one cycle after the `s_ready` cycle.
- **Miss:** request sampled at cycle 0, `m_ready` and `m_err` at cycle 1.
- **Timeout:** ACCESS lasts exactly `TIMEOUT` cycles. `m_ready` and `m_err` follow in the next cycle.
- **Ready on the final timeout cycle:** the access completes normally with no error.
- Outputs `m_rdata`, `m_ready`, `m_err` are registered.

## Test plan

1. **Zero-wait read:** default params; read at 0x0000_1004; slave 1 ties `s_ready=1` with data 0xDEADBEEF. Required: `s_cs=4'b0010` and `s_addr=0x004` in cycle 1; `m_ready=1`, `m_rdata=0xDEADBEEF`, `m_err=0` in cycle 2.
2. **Stalled byte write:** write `m_wr=4'b0010`, data 0x0000AB00, addr 0x2008; slave 2 raises ready after 3 stall cycles. Required: `s_cs[2]` and `s_wr=4'b0010` held 4 cycles; `m_ready` 5 cycles after the sample cycle; `m_err=0`; `m_rdata=0`.
3. **Decode miss:** read at 0x0000_4000. Required: no `s_cs` bit ever set; `m_ready=1`, `m_err=1`, `m_rdata=0` in cycle 1. Repeat with `BASE_ADDR=0x1000`, addr 0x0FFC: same result.
4. **Timeout:** slave 3 never readies (`TIMEOUT=15`). Required: `s_cs[3]` high exactly 15 cycles, then `m_ready=1`, `m_err=1`, `m_rdata=0`. Repeat with ready on the 15th ACCESS cycle: normal completion, `m_err=0`.
5. **Malformed request and reset:**
   - Issue `m_rd=1` with `m_wr=4'b1111`. Required: error response in cycle 1, no slave access.
   - Assert `rst=0` during cycle 2 of an ACCESS. Required: all outputs 0 asynchronously; after release, a new read completes normally.
6. **Back-to-back:** alternating reads to slaves 0 and 1, zero-wait. Required: one `m_ready` every 3 cycles with correct per-slave data, and no `s_cs` overlap.

Source files
------------

// File: rtl/dbus_interconnect.sv
// Data-bus interconnect: decodes the hart's data port into NUM_SLAVES uniform regions,
// registers each access, and ends unmapped, malformed or stalled accesses with a bus error.
module dbus_interconnect #(
  parameter int                NUM_SLAVES  = 4,
  parameter int                ADDR_W      = 32,
  parameter int                DATA_W      = 32,
  parameter int                REGION_BITS = 12,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter int                TIMEOUT     = 15
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         m_rd,
  input  logic [DATA_W/8-1:0]          m_wr,
  input  logic [ADDR_W-1:0]            m_addr,
  input  logic [DATA_W-1:0]            m_wdata,
  output logic [DATA_W-1:0]            m_rdata,
  output logic                         m_ready,
  output logic                         m_err,
  output logic [NUM_SLAVES-1:0]        s_cs,
  output logic                         s_rd,
  output logic [DATA_W/8-1:0]          s_wr,
  output logic [REGION_BITS-1:0]       s_addr,
  output logic [DATA_W-1:0]            s_wdata,
  input  logic [NUM_SLAVES*DATA_W-1:0] s_rdata,
  input  logic [NUM_SLAVES-1:0]        s_ready
);

  localparam int SW    = DATA_W / 8;
  localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t                  state_reg, state_next;
  logic [IDX_W-1:0]        idx_reg;
  logic                    rd_reg;
  logic [SW-1:0]           wr_reg;
  logic [REGION_BITS-1:0]  s_addr_reg;
  logic [DATA_W-1:0]       s_wdata_reg;
  logic [CNT_W-1:0]        cnt_reg, cnt_next;
  logic [DATA_W-1:0]       m_rdata_reg;
  logic                    m_err_reg;
  logic                    m_ready_reg;

  logic [ADDR_W-1:0]       offset;
  logic [ADDR_W-1:0]       idx_full;
  logic                    req;
  logic                    miss;
  logic                    start;
  logic                    resp_load;
  logic                    resp_err;
  logic [DATA_W-1:0]       resp_data;
  logic                    sel_ready;
  logic [DATA_W-1:0]       sel_rdata;
  logic [DATA_W-1:0]       slv_rdata [NUM_SLAVES];

  assign offset   = m_addr - BASE_ADDR;
  assign idx_full = offset >> REGION_BITS;
  assign req      = m_rd | (|m_wr);
  // A simultaneous read and write is rejected like an unmapped address.
  assign miss     = (m_addr < BASE_ADDR) || (idx_full >= ADDR_W'(NUM_SLAVES)) || (m_rd && (|m_wr));

  generate
    for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_slave
      assign slv_rdata[gi] = s_rdata[gi*DATA_W +: DATA_W];
      assign s_cs[gi]      = (state_reg == ACCESS) && (idx_reg == IDX_W'(gi));
    end
  endgenerate

  assign sel_ready = s_ready[idx_reg];
  assign sel_rdata = slv_rdata[idx_reg];

  // Slave strobes decode straight from the state register so reset drops them at once.
  assign s_rd    = (state_reg == ACCESS) && rd_reg;
  assign s_wr    = (state_reg == ACCESS) ? wr_reg : '0;
  assign s_addr  = s_addr_reg;
  assign s_wdata = s_wdata_reg;
  assign m_rdata = m_rdata_reg;
  assign m_ready = m_ready_reg;
  assign m_err   = m_err_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= IDLE;
    else      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    start      = 1'b0;
    resp_load  = 1'b0;
    resp_err   = 1'b0;
    resp_data  = '0;
    case (state_reg)
      IDLE: begin
        if (req) begin
          start = 1'b1;
          if (miss) begin
            state_next = RESP;
            resp_load  = 1'b1;
            resp_err   = 1'b1;
          end else begin
            state_next = ACCESS;
            cnt_next   = '0;
          end
        end
      end
      ACCESS: begin
        if (sel_ready) begin
          state_next = RESP;
          resp_load  = 1'b1;
          resp_data  = rd_reg ? sel_rdata : '0;
        end else if ((TIMEOUT > 0) && (cnt_reg == CNT_LAST)) begin
          state_next = RESP;
          resp_load  = 1'b1;
          resp_err   = 1'b1;
        end else if (cnt_reg != {CNT_W{1'b1}}) begin
          // Saturating: with the timeout disabled the counter must not wrap.
          cnt_next = cnt_reg + 1'b1;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_reg     <= '0;
      rd_reg      <= 1'b0;
      wr_reg      <= '0;
      s_addr_reg  <= '0;
      s_wdata_reg <= '0;
      cnt_reg     <= '0;
      m_rdata_reg <= '0;
      m_err_reg   <= 1'b0;
      m_ready_reg <= 1'b0;
    end else begin
      cnt_reg     <= cnt_next;
      m_ready_reg <= resp_load;
      m_err_reg   <= resp_load & resp_err;
      m_rdata_reg <= resp_load ? resp_data : '0;
      if (start) begin
        idx_reg     <= idx_full[IDX_W-1:0];
        rd_reg      <= m_rd;
        wr_reg      <= m_wr;
        s_addr_reg  <= m_addr[REGION_BITS-1:0];
        s_wdata_reg <= m_wdata;
      end
    end
  end

endmodule

// File: tb/tb_dbus_interconnect.sv
// Directed bench for dbus_interconnect: scripted slaves with programmable stall,
// expected responses queued at issue and checked when m_ready arrives.
module tb_dbus_interconnect;

  localparam int NS  = 4;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int SW  = DW / 8;
  localparam int RB  = 12;
  localparam int TMO = 15;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic          m_rd = 1'b0;
  logic [SW-1:0] m_wr = '0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0;
  logic [DW-1:0] m_rdata;
  logic          m_ready, m_err;
  logic [NS-1:0] s_cs, s_ready;
  logic          s_rd;
  logic [SW-1:0] s_wr;
  logic [RB-1:0] s_addr;
  logic [DW-1:0] s_wdata;
  logic [NS*DW-1:0] s_rdata;

  // Second instance with a non-zero base address, zero-wait slaves
  logic          b_rd = 1'b0;
  logic [SW-1:0] b_wr = '0;
  logic [AW-1:0] b_addr = '0;
  logic [DW-1:0] b_wdata = '0;
  logic [DW-1:0] b_m_rdata;
  logic          b_m_ready, b_m_err;
  logic [NS-1:0] b_s_cs;
  logic          b_s_rd;
  logic [SW-1:0] b_s_wr;
  logic [RB-1:0] b_s_addr;
  logic [DW-1:0] b_s_wdata;

  logic [DW-1:0] slv_data [NS];
  int            stall [NS];
  int            acc_cyc = 0;

  int nchecks = 0;
  int nfail   = 0;

  typedef struct {
    logic [DW-1:0] data;
    logic          err;
    int            lat;
    int            slave;
    int            cs_cyc;
  } exp_t;
  exp_t sb[$];

  logic [RB-1:0] last_addr;
  logic [SW-1:0] last_wr;
  logic          last_rd;
  logic [DW-1:0] last_wdata;

  initial begin
    slv_data[0] = 32'h1111_0000;
    slv_data[1] = 32'hDEAD_BEEF;
    slv_data[2] = 32'h2222_2222;
    slv_data[3] = 32'h3333_3333;
    stall[0] = 0;
    stall[1] = 0;
    stall[2] = 0;
    stall[3] = 1000;
  end

  generate
    for (genvar gi = 0; gi < NS; gi++) begin : g_slv
      assign s_rdata[gi*DW +: DW] = slv_data[gi];
      assign s_ready[gi] = s_cs[gi] && (acc_cyc >= stall[gi]);
    end
  endgenerate

  // Number of ACCESS cycles already elapsed for the current transaction
  always @(posedge clk) acc_cyc <= (|s_cs) ? acc_cyc + 1 : 0;

  dbus_interconnect #(
    .NUM_SLAVES(NS), .ADDR_W(AW), .DATA_W(DW), .REGION_BITS(RB),
    .BASE_ADDR(32'h0), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst),
    .m_rd(m_rd), .m_wr(m_wr), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ready(m_ready), .m_err(m_err),
    .s_cs(s_cs), .s_rd(s_rd), .s_wr(s_wr), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_rdata(s_rdata), .s_ready(s_ready)
  );

  dbus_interconnect #(
    .NUM_SLAVES(NS), .ADDR_W(AW), .DATA_W(DW), .REGION_BITS(RB),
    .BASE_ADDR(32'h1000), .TIMEOUT(TMO)
  ) dut_b (
    .clk(clk), .rst(rst),
    .m_rd(b_rd), .m_wr(b_wr), .m_addr(b_addr), .m_wdata(b_wdata),
    .m_rdata(b_m_rdata), .m_ready(b_m_ready), .m_err(b_m_err),
    .s_cs(b_s_cs), .s_rd(b_s_rd), .s_wr(b_s_wr), .s_addr(b_s_addr), .s_wdata(b_s_wdata),
    .s_rdata(s_rdata), .s_ready(b_s_cs)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchecks++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one request and wait (bounded) for its response.
  task automatic txn(input logic rd, input logic [SW-1:0] wr, input logic [AW-1:0] addr,
                     input logic [DW-1:0] wd, input logic [DW-1:0] ed, input logic ee,
                     input int lat, input int slave, input int cs_cyc);
    exp_t e;
    int   n, cs_n, other;
    logic done;
    e.data = ed; e.err = ee; e.lat = lat; e.slave = slave; e.cs_cyc = cs_cyc;
    sb.push_back(e);
    m_rd = rd; m_wr = wr; m_addr = addr; m_wdata = wd;
    n = 0; cs_n = 0; other = 0; done = 1'b0;
    while (!done && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (|s_cs) begin
        if (slave >= 0 && s_cs == (NS'(1) << slave)) begin
          cs_n++;
          last_addr = s_addr; last_wr = s_wr; last_rd = s_rd; last_wdata = s_wdata;
        end else begin
          other++;
        end
      end
      if (m_ready) done = 1'b1;
    end
    e = sb.pop_front();
    chk("response_seen", done, 1'b1);
    chk("m_rdata", m_rdata, e.data);
    chk("m_err", m_err, e.err);
    chk("latency", n, e.lat);
    chk("cs_cycles", cs_n, e.cs_cyc);
    chk("cs_wrong_slave", other, 0);
    $display("txn rd=%0b wr=%b addr=%h -> rdata=%h err=%0b lat=%0d cs_cycles=%0d",
             rd, wr, addr, m_rdata, m_err, n, cs_n);
  endtask

  task automatic idle();
    m_rd = 1'b0; m_wr = '0;
    @(posedge clk); #1;
    chk("ready_pulse_width", m_ready, 1'b0);
    chk("idle_cs", s_cs, '0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    chk("rst_m_ready", m_ready, 1'b0);
    chk("rst_m_err", m_err, 1'b0);
    chk("rst_m_rdata", m_rdata, '0);
    chk("rst_s_cs", s_cs, '0);
    chk("rst_s_rd", s_rd, 1'b0);
    chk("rst_s_wr", s_wr, '0);
    chk("rst_s_addr", s_addr, '0);
    chk("rst_s_wdata", s_wdata, '0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;

    // Zero-wait read
    txn(1'b1, 4'b0000, 32'h0000_1004, '0, 32'hDEAD_BEEF, 1'b0, 2, 1, 1);
    chk("t1_s_addr", last_addr, 12'h004);
    chk("t1_s_rd", last_rd, 1'b1);
    idle();

    // Stalled byte write
    stall[2] = 3;
    txn(1'b0, 4'b0010, 32'h0000_2008, 32'h0000_AB00, '0, 1'b0, 5, 2, 4);
    chk("t2_s_wr", last_wr, 4'b0010);
    chk("t2_s_wdata", last_wdata, 32'h0000_AB00);
    chk("t2_s_rd", last_rd, 1'b0);
    chk("t2_s_addr", last_addr, 12'h008);
    idle();
    stall[2] = 0;

    // Decode miss
    txn(1'b1, 4'b0000, 32'h0000_4000, '0, '0, 1'b1, 1, -1, 0);
    idle();

    // Below base address on the offset instance, then a hit on it
    b_addr = 32'h0000_0FFC; b_rd = 1'b1;
    @(posedge clk); #1;
    chk("b_miss_ready", b_m_ready, 1'b1);
    chk("b_miss_err", b_m_err, 1'b1);
    chk("b_miss_rdata", b_m_rdata, '0);
    chk("b_miss_cs", b_s_cs, '0);
    b_rd = 1'b0;
    @(posedge clk); #1;
    b_addr = 32'h0000_2004; b_rd = 1'b1;
    @(posedge clk); #1;
    chk("b_hit_cs", b_s_cs, 4'b0010);
    chk("b_hit_addr", b_s_addr, 12'h004);
    @(posedge clk); #1;
    chk("b_hit_ready", b_m_ready, 1'b1);
    chk("b_hit_err", b_m_err, 1'b0);
    chk("b_hit_rdata", b_m_rdata, 32'hDEAD_BEEF);
    $display("txn offset-base read addr=%h -> rdata=%h err=%0b", b_addr, b_m_rdata, b_m_err);
    b_rd = 1'b0;
    @(posedge clk); #1;

    // Timeout, then ready on the final allowed cycle
    txn(1'b1, 4'b0000, 32'h0000_3010, '0, '0, 1'b1, TMO + 1, 3, TMO);
    idle();
    stall[3] = TMO - 1;
    txn(1'b1, 4'b0000, 32'h0000_3010, '0, 32'h3333_3333, 1'b0, TMO + 1, 3, TMO);
    idle();
    stall[3] = 1000;

    // Malformed read+write
    txn(1'b1, 4'b1111, 32'h0000_1000, 32'h1234_5678, '0, 1'b1, 1, -1, 0);
    idle();

    // Reset during the second ACCESS cycle
    m_rd = 1'b1; m_addr = 32'h0000_3000;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_reset_cs", s_cs, 4'b1000);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_cs", s_cs, '0);
    chk("async_rst_rd", s_rd, 1'b0);
    chk("async_rst_ready", m_ready, 1'b0);
    chk("async_rst_err", m_err, 1'b0);
    chk("async_rst_rdata", m_rdata, '0);
    m_rd = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      chk("no_ready_in_reset", m_ready, 1'b0);
    end
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    txn(1'b1, 4'b0000, 32'h0000_2000, '0, 32'h2222_2222, 1'b0, 2, 2, 1);
    idle();

    // Back-to-back alternating reads to slaves 0 and 1
    for (int k = 0; k < 4; k++) begin
      txn(1'b1, 4'b0000, (k % 2) ? 32'h0000_1008 : 32'h0000_0008, '0,
          (k % 2) ? 32'hDEAD_BEEF : 32'h1111_0000, 1'b0, (k == 0) ? 2 : 3, k % 2, 1);
    end
    idle();

    chk("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", nchecks, nfail);
    $finish;
  end

endmodule
